// File: rtl/dht_sched_pkg.sv
// Shared definitions for the DHT sample scheduler.
//   state_t         : scheduler FSM states
//   SRC_*           : request source indices into pending/grant vectors
//   DEF_*           : parameter defaults used by dht_sample_sched
//   max3 / src_of   : elaboration and encoding helpers
package dht_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT,
    ST_GAP
  } state_t;

  localparam int SRC_PER  = 0;
  localparam int SRC_UI   = 1;
  localparam int SRC_HOST = 2;

  localparam int unsigned DEF_PULSE_CYC   = 16;
  localparam int unsigned DEF_TIMEOUT_CYC = 5_000_000;
  localparam int unsigned DEF_MIN_GAP_CYC = 200_000_000;
  localparam int unsigned DEF_PERIOD_CYC  = 500_000_000;
  localparam int unsigned DEF_ALARM_HI    = 30;
  localparam int unsigned DEF_ALARM_LO    = 28;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // One-hot grant to source index.
  function automatic logic [1:0] src_of(input logic [2:0] oh);
    if (oh[SRC_HOST]) return 2'(SRC_HOST);
    if (oh[SRC_UI])   return 2'(SRC_UI);
    return 2'(SRC_PER);
  endfunction

endpackage

// File: rtl/dht_sample_sched_arb.sv
// dht_rr_arb3: combinational 3-way round-robin arbiter.
//   pending  in  3 : request flags, indexed by SRC_*
//   last_src in  2 : index of the most recently granted source
//   grant    out 3 : one-hot winner, searching from last_src+1 upward (mod 3); 0 if none
module dht_rr_arb3
  import dht_sched_pkg::*;
(
  input  logic [2:0] pending,
  input  logic [1:0] last_src,
  output logic [2:0] grant
);

  always_comb begin
    grant = '0;
    case (last_src)
      2'(SRC_PER): begin
        if      (pending[SRC_UI])   grant[SRC_UI]   = 1'b1;
        else if (pending[SRC_HOST]) grant[SRC_HOST] = 1'b1;
        else if (pending[SRC_PER])  grant[SRC_PER]  = 1'b1;
      end
      2'(SRC_UI): begin
        if      (pending[SRC_HOST]) grant[SRC_HOST] = 1'b1;
        else if (pending[SRC_PER])  grant[SRC_PER]  = 1'b1;
        else if (pending[SRC_UI])   grant[SRC_UI]   = 1'b1;
      end
      default: begin
        if      (pending[SRC_PER])  grant[SRC_PER]  = 1'b1;
        else if (pending[SRC_UI])   grant[SRC_UI]   = 1'b1;
        else if (pending[SRC_HOST]) grant[SRC_HOST] = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dht_sample_sched.sv
// dht_sample_sched: arbitrates periodic / button / host read requests for a
// DHT sensor reader, pulses its trigger, waits for completion or timeout,
// then enforces a minimum idle gap before the next read.
//   clk_in, rst_n (async, active-low)
//   periodic_en        : enables the PERIOD_CYC request timer
//   req_ui, req_host   : single-cycle request pulses
//   sens_done, sens_temp, sens_hum : reader completion and results
//   sample_en, busy, grant[2:0]    : reader trigger, activity, one-hot source
//   temp_out, hum_out, data_valid  : last captured reading
//   err_timeout (pulse), timeout_cnt (saturating), alarm
// Optional: define DHT_SCHED_ALARM_EN to build the temperature alarm with
// hysteresis; otherwise alarm is tied low.
module dht_sample_sched
  import dht_sched_pkg::*;
#(
  parameter int unsigned PULSE_CYC   = DEF_PULSE_CYC,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned MIN_GAP_CYC = DEF_MIN_GAP_CYC,
  parameter int unsigned PERIOD_CYC  = DEF_PERIOD_CYC,
  parameter int unsigned ALARM_HI    = DEF_ALARM_HI,
  parameter int unsigned ALARM_LO    = DEF_ALARM_LO
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       periodic_en,
  input  logic       req_ui,
  input  logic       req_host,
  input  logic       sens_done,
  input  logic [7:0] sens_temp,
  input  logic [7:0] sens_hum,
  output logic       sample_en,
  output logic       busy,
  output logic [2:0] grant,
  output logic [7:0] temp_out,
  output logic [7:0] hum_out,
  output logic       data_valid,
  output logic       err_timeout,
  output logic [7:0] timeout_cnt,
  output logic       alarm
);

  // One phase counter serves TRIG, WAIT and GAP, sized for the longest phase.
  localparam int unsigned SEQ_MAX = max3(PULSE_CYC, TIMEOUT_CYC, MIN_GAP_CYC);
  localparam int unsigned CW = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;
  localparam int unsigned PW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;

  localparam logic [CW-1:0] PULSE_LAST   = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(MIN_GAP_CYC - 1);
  localparam logic [PW-1:0] PER_LAST     = PW'(PERIOD_CYC - 1);

  state_t        state;
  logic [CW-1:0] seq_cnt;
  logic [PW-1:0] per_cnt;
  logic          per_tick;
  logic [2:0]    pending;
  logic [2:0]    req_vec;
  logic [2:0]    clr_vec;
  logic [2:0]    arb_grant;
  logic [1:0]    last_src;

  dht_rr_arb3 u_arb (
    .pending  (pending),
    .last_src (last_src),
    .grant    (arb_grant)
  );

  assign per_tick = periodic_en && (per_cnt == PER_LAST);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)                       per_cnt <= '0;
    else if (!periodic_en || per_tick) per_cnt <= '0;
    else                              per_cnt <= per_cnt + PW'(1);
  end

  always_comb begin
    req_vec           = '0;
    req_vec[SRC_PER]  = per_tick;
    req_vec[SRC_UI]   = req_ui;
    req_vec[SRC_HOST] = req_host;
    clr_vec           = (state == ST_IDLE) ? arb_grant : '0;
  end

  // Set after clear: a request arriving in its grant cycle stays pending.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~clr_vec) | req_vec;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      seq_cnt     <= '0;
      sample_en   <= 1'b0;
      busy        <= 1'b0;
      grant       <= '0;
      last_src    <= 2'(SRC_HOST);
      temp_out    <= '0;
      hum_out     <= '0;
      data_valid  <= 1'b0;
      err_timeout <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      err_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|arb_grant) begin
            state     <= ST_TRIG;
            seq_cnt   <= '0;
            sample_en <= 1'b1;
            busy      <= 1'b1;
            grant     <= arb_grant;
            last_src  <= src_of(arb_grant);
          end
        end
        ST_TRIG: begin
          if (seq_cnt == PULSE_LAST) begin
            state     <= ST_WAIT;
            seq_cnt   <= '0;
            sample_en <= 1'b0;
          end else begin
            seq_cnt <= seq_cnt + CW'(1);
          end
        end
        ST_WAIT: begin
          if (sens_done) begin
            state      <= ST_GAP;
            seq_cnt    <= '0;
            grant      <= '0;
            temp_out   <= sens_temp;
            hum_out    <= sens_hum;
            data_valid <= 1'b1;
          end else if (seq_cnt == TIMEOUT_LAST) begin
            state       <= ST_GAP;
            seq_cnt     <= '0;
            grant       <= '0;
            err_timeout <= 1'b1;
            if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
          end else begin
            seq_cnt <= seq_cnt + CW'(1);
          end
        end
        ST_GAP: begin
          if (seq_cnt == GAP_LAST) begin
            state   <= ST_IDLE;
            seq_cnt <= '0;
            busy    <= 1'b0;
          end else begin
            seq_cnt <= seq_cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DHT_SCHED_ALARM_EN
  // Hysteresis band: between ALARM_LO and ALARM_HI the alarm holds its state.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      alarm <= 1'b0;
    end else if (data_valid) begin
      if (temp_out > 8'(ALARM_HI))      alarm <= 1'b1;
      else if (temp_out < 8'(ALARM_LO)) alarm <= 1'b0;
    end
  end
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_dht_sample_sched.sv
module tb_dht_sample_sched;

  localparam int PULSE  = 4;
  localparam int TOUT   = 50;
  localparam int GAP    = 100;
  localparam int PERIOD = 1000;
  localparam int AHI    = 30;
  localparam int ALO    = 28;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       periodic_en, req_ui, req_host, sens_done;
  logic [7:0] sens_temp, sens_hum;
  logic       sample_en, busy, data_valid, err_timeout, alarm;
  logic [2:0] grant;
  logic [7:0] temp_out, hum_out, timeout_cnt;

  always #5 clk = ~clk;

  dht_sample_sched #(
    .PULSE_CYC   (PULSE),
    .TIMEOUT_CYC (TOUT),
    .MIN_GAP_CYC (GAP),
    .PERIOD_CYC  (PERIOD)
  ) dut (
    .clk_in      (clk),
    .rst_n       (rst_n),
    .periodic_en (periodic_en),
    .req_ui      (req_ui),
    .req_host    (req_host),
    .sens_done   (sens_done),
    .sens_temp   (sens_temp),
    .sens_hum    (sens_hum),
    .sample_en   (sample_en),
    .busy        (busy),
    .grant       (grant),
    .temp_out    (temp_out),
    .hum_out     (hum_out),
    .data_valid  (data_valid),
    .err_timeout (err_timeout),
    .timeout_cnt (timeout_cnt),
    .alarm       (alarm)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: pending set, last-served source, captured values.
  bit pend[3];
  int last_src;
  int m_temp, m_hum, m_tcnt;
  bit m_valid, m_alarm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pend[i] = 1'b0;
    last_src = 2;
    m_temp = 0; m_hum = 0; m_tcnt = 0; m_valid = 1'b0; m_alarm = 1'b0;
  endtask

  function automatic int rr_pick();
    for (int i = 1; i <= 3; i++) begin
      int s;
      s = (last_src + i) % 3;
      if (pend[s]) return s;
    end
    return -1;
  endfunction

  task automatic check_values(input string tag);
    check({tag, "_temp"}, temp_out, m_temp);
    check({tag, "_hum"}, hum_out, m_hum);
    check({tag, "_valid"}, data_valid, m_valid);
    check({tag, "_tcnt"}, timeout_cnt, m_tcnt);
    check({tag, "_alarm"}, alarm, m_alarm);
  endtask

  // Called at a negedge while idle.
  task automatic pulse_req(input bit ui, input bit host);
    req_ui = ui; req_host = host;
    if (ui) pend[1] = 1'b1;
    if (host) pend[2] = 1'b1;
    @(negedge clk);
    req_ui = 1'b0; req_host = 1'b0;
  endtask

  // Serve one read. done_k < 0 means the reader never answers.
  task automatic do_read(input int done_k, input int temp, input int hum, input bit extra);
    int src, w, hi, cnt, xsrc;
    bit timed_out;
    logic [2:0] exp_g;
    src = rr_pick();
    if (src < 0) return;
    pend[src] = 1'b0;
    last_src = src;
    exp_g = 3'(1 << src);
    xsrc = 1 + int'($urandom % 2);
    w = 0;
    while (sample_en !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
    check("trig_rise", sample_en, 1);
    if (sample_en !== 1'b1) return;
    check("grant_trig", grant, exp_g);
    check("busy_trig", busy, 1);
    hi = 0;
    while (sample_en === 1'b1 && hi < 20) begin hi++; @(negedge clk); end
    check("pulse_width", hi, PULSE);
    for (int k = 0; k < 200; k++) begin
      if (k == done_k) begin
        sens_done = 1'b1; sens_temp = 8'(temp); sens_hum = 8'(hum);
      end
      // Same source pulsed twice during WAIT must merge into one read.
      if (extra && (k == 2 || k == 4)) begin
        if (xsrc == 1) req_ui = 1'b1; else req_host = 1'b1;
        pend[xsrc] = 1'b1;
      end
      @(negedge clk);
      sens_done = 1'b0; req_ui = 1'b0; req_host = 1'b0;
      sens_temp = 8'($urandom); sens_hum = 8'($urandom);
      if (k == done_k || (done_k < 0 && k == TOUT - 1)) break;
      check("wait_hold", {err_timeout, sample_en, grant}, {1'b0, 1'b0, exp_g});
    end
    timed_out = (done_k < 0);
    if (!timed_out) begin
      m_temp = temp; m_hum = hum; m_valid = 1'b1;
    end else if (m_tcnt < 255) begin
      m_tcnt++;
    end
    check("err_timeout", err_timeout, timed_out);
    check("grant_gap", grant, 0);
    check("busy_gap", busy, 1);
    check("cap_temp", temp_out, m_temp);
    check("cap_hum", hum_out, m_hum);
    check("cap_valid", data_valid, m_valid);
    check("tcnt", timeout_cnt, m_tcnt);
`ifdef DHT_SCHED_ALARM_EN
    if (m_valid) begin
      if (m_temp > AHI) m_alarm = 1'b1;
      else if (m_temp < ALO) m_alarm = 1'b0;
    end
`endif
    cnt = 1;
    @(negedge clk);
    check("alarm", alarm, m_alarm);
    check("err_pulse", err_timeout, 0);
    while (busy === 1'b1 && cnt < 400) begin
      cnt++;
      if (cnt == 10) begin sens_done = 1'b1; sens_temp = 8'($urandom); sens_hum = 8'($urandom); end
      @(negedge clk);
      sens_done = 1'b0;
    end
    check("gap_len", cnt, GAP);
    check("ignore_done", temp_out, m_temp);
    check("idle_outputs", {sample_en, grant}, 4'b0);
  endtask

  function automatic int rand_done();
    int r;
    r = int'($urandom % 4);
    if (r == 0) return -1;
    if (r == 1) return TOUT - 1;
    return int'($urandom_range(0, TOUT - 2));
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int temps[3];
    int w;
    rst_n = 1'b0; periodic_en = 1'b0; req_ui = 1'b0; req_host = 1'b0;
    sens_done = 1'b0; sens_temp = '0; sens_hum = '0;
    model_reset();
    #1;
    check("rst_ctrl", {sample_en, busy, grant, err_timeout}, 6'b0);
    check_values("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Host read, answer 20 cycles after trigger falls.
    pulse_req(0, 1); do_read(20, 25, 60, 0);
    // Answer and timeout coincide: answer wins.
    pulse_req(0, 1); do_read(TOUT - 1, 33, 44, 0);
    // No answer: timeout.
    pulse_req(1, 0); do_read(-1, 0, 0, 0);
    // Alarm hysteresis sequence.
    temps = '{31, 29, 27};
    foreach (temps[i]) begin
      pulse_req(0, 1); do_read(10, temps[i], 50, 0);
    end

    // Request held across the grant cycle survives as a second read.
    req_host = 1'b1; pend[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    req_host = 1'b0;
    do_read(5, 22, 40, 0);
    pend[2] = 1'b1;
    do_read(6, 23, 41, 0);
    repeat (20) @(negedge clk);
    check("no_extra_read", busy, 0);

    // Randomized traffic.
    for (int t = 0; t < 30; t++) begin
      bit ui, host;
      ui = 1'($urandom % 2);
      host = 1'($urandom % 2);
      if (!ui && !host) host = 1'b1;
      pulse_req(ui, host);
      while (pend[0] || pend[1] || pend[2])
        do_read(rand_done(), int'($urandom_range(20, 40)), int'($urandom_range(0, 100)), 1'($urandom % 2));
    end

    // Reset while the trigger is high.
    pulse_req(0, 1);
    w = 0;
    while (sample_en !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    check("rst_trig_rise", sample_en, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_ctrl", {sample_en, busy, grant, err_timeout}, 6'b0);
    check_values("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_req(0, 1); do_read(15, 26, 55, 0);

    // Periodic request coinciding with button and host requests.
    periodic_en = 1'b1;
    for (int n = 1; n < PERIOD; n++) @(negedge clk);
    check("per_early", sample_en, 0);
    req_ui = 1'b1; req_host = 1'b1;
    @(negedge clk);
    req_ui = 1'b0; req_host = 1'b0;
    check("per_no_trig", sample_en, 0);
    @(negedge clk);
    periodic_en = 1'b0;
    check("per_latency", sample_en, 1);
    for (int i = 0; i < 3; i++) pend[i] = 1'b1;
    for (int i = 0; i < 3; i++) do_read(rand_done(), int'($urandom_range(20, 40)), 70, 0);
    repeat (20) @(negedge clk);
    check("per_disabled", busy, 0);

    // Drive the timeout counter into saturation.
    for (int i = 0; i < 256; i++) begin
      pulse_req(0, 1); do_read(-1, 0, 0, 0);
    end
    check("tcnt_sat", timeout_cnt, 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dht_sample_sched.md
DHT_SAMPLE_SCHED -- requirements
Module: dht_sample_sched

Interface
REQ-001 SHALL have parameter PULSE_CYC, default 16, sample_en high width in cycles.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 5_000_000, max cycles from trigger to sens_done.
REQ-003 SHALL have parameter MIN_GAP_CYC, default 200_000_000, minimum idle cycles between reads.
REQ-004 SHALL have parameter PERIOD_CYC, default 500_000_000, periodic request interval.
REQ-005 SHALL have parameters ALARM_HI (30) and ALARM_LO (28), alarm set/clear thresholds in degrees C.
REQ-006 SHALL have ports: clk_in in 1 clock; rst_n in 1 reset, asynchronous, active-low.
REQ-007 SHALL have ports: periodic_en in 1 timer enable; req_ui in 1 button request pulse; req_host in 1 host request pulse.
REQ-008 SHALL have ports: sens_done in 1 reader-complete pulse; sens_temp in 8, sens_hum in 8 reader results.
REQ-009 SHALL have ports: sample_en out 1 reader trigger; busy out 1; grant out 3 one-hot active source (0 periodic, 1 ui, 2 host).
REQ-010 SHALL have ports: temp_out out 8; hum_out out 8; data_valid out 1; err_timeout out 1 pulse; timeout_cnt out 8; alarm out 1.

Function
REQ-011 SHALL implement FSM IDLE -> TRIG -> WAIT -> GAP -> IDLE.
REQ-012 SHALL latch each request pulse into a per-source pending flag; repeat requests while pending merge into one read.
REQ-013 SHALL, in IDLE with any pending flag, grant round-robin starting after last-granted source, clear its pending flag, enter TRIG next cycle.
REQ-014 SHALL let a request pulse arriving in the same cycle its flag is cleared win (flag remains set).
REQ-015 SHALL drive sample_en high for exactly PULSE_CYC cycles in TRIG, then enter WAIT; grant held one-hot from TRIG entry until GAP entry.
REQ-016 SHALL, on sens_done in WAIT, register sens_temp/sens_hum into temp_out/hum_out, set data_valid, enter GAP.
REQ-017 SHALL, after TIMEOUT_CYC cycles in WAIT without sens_done, pulse err_timeout one cycle, increment timeout_cnt saturating at 255, leave outputs unchanged, enter GAP.
REQ-018 SHALL give sens_done priority over timeout in the same cycle; sens_done outside WAIT is ignored.
REQ-019 SHALL remain in GAP MIN_GAP_CYC cycles, then enter IDLE; busy high in all states except IDLE.
REQ-020 SHALL run periodic counter only while periodic_en high, set pending[0] when it reaches PERIOD_CYC-1 and wrap to 0; periodic_en low clears the counter.
REQ-021 SHALL size all counters with $clog2 of their parameter; no counter wraps except the periodic one.

Reset
REQ-022 SHALL on rst_n low immediately: state IDLE, sample_en 0, busy 0, grant 0, pending 0, last-granted = source 2, all counters 0.
REQ-023 SHALL reset temp_out 0, hum_out 0, data_valid 0, err_timeout 0, timeout_cnt 0, alarm 0; reset mid-read abandons the read.

Configuration
REQ-024 SHALL, with DHT_SCHED_ALARM_EN defined, register alarm: set when temp_out > ALARM_HI, clear when temp_out < ALARM_LO, hold otherwise, evaluated only while data_valid.
REQ-025 SHALL, without DHT_SCHED_ALARM_EN, tie alarm to 0 and instantiate no alarm logic.

Structure
REQ-026 SHALL place state enum, source index constants (SRC_PER, SRC_UI, SRC_HOST) and parameter defaults in package dht_sched_pkg.
REQ-027 SHALL implement the round-robin selection as sub-module dht_rr_arb3 (3-bit pending, last-granted in, one-hot grant out, combinational).

Verification (PULSE_CYC=4, TIMEOUT_CYC=50, MIN_GAP_CYC=100, PERIOD_CYC=1000)
REQ-028 SHALL cover: req_host pulse, sens_done 20 cycles after sample_en falls with temp 25 hum 60 -> sample_en high 4 cycles, grant=100, temp_out 25, hum_out 60, data_valid 1, busy low 100 cycles later.
REQ-029 SHALL cover: req_ui, req_host, periodic pending together -> grants 001, 010, 100 in order, each separated by >=100 GAP cycles.
REQ-030 SHALL cover: no sens_done -> err_timeout pulse 50 cycles into WAIT, timeout_cnt 1, temp_out unchanged; 256 timeouts -> timeout_cnt 255.
REQ-031 SHALL cover: sens_done and timeout same cycle -> data captured, err_timeout 0, timeout_cnt unchanged.
REQ-032 SHALL cover: rst_n low during TRIG -> sample_en 0 same cycle, all outputs reset, req_host afterwards -> grant 100 first-served normally.
REQ-033 SHALL cover (ALARM_EN): temps 31, 29, 27 -> alarm 1, 1, 0; without macro alarm stays 0.
